// File: rtl/alu_issue_ctrl.sv
// ALU issue/writeback controller: 8x16 regfile, accept -> 1-cycle ALU issue -> registered writeback, 1 instr per 2 cycles.
// in_ready low during ISSUE; `define STICKY_OVF_EN to build the accumulated-overflow flag (ovf_sticky/ovf_clr).
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_code,
    input  logic [15:0] alu_c,
    input  logic        alu_ovf,
    output logic        res_valid,
    output logic [2:0]  res_rd,
    output logic [15:0] res_data,
    output logic        res_ovf,
    output logic        ovf_sticky,
    input  logic        ovf_clr
);

    typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_rf [0:7];
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [4:0]  r_alu_code;
    logic [2:0]  r_rd;
    logic        r_res_valid;
    logic [2:0]  r_res_rd;
    logic [15:0] r_res_data;
    logic        r_res_ovf;

    logic        w_accept;
    logic        w_wb_en;
    logic        w_ovf_masked;
    logic [2:0]  w_ra;
    logic [2:0]  w_rb;
    logic        w_unused;

    assign w_ra         = in_instr[7:5];
    assign w_rb         = in_instr[4:2];
    assign w_accept     = in_valid & in_ready;
    assign w_wb_en      = (r_state == S_ISSUE);
    assign w_ovf_masked = alu_ovf & (r_alu_code[4:3] == 2'b00);
    assign w_unused     = ^{in_instr[1:0], ovf_clr};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Entry 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_rf[i] <= 16'h0000;
        end else begin
            for (int i = 1; i < 8; i++) begin
                if (w_wb_en && (r_rd == 3'(i)))          r_rf[i] <= alu_c;
                else if (wr_en && (wr_addr == 3'(i)))    r_rf[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a    <= 16'h0000;
            r_alu_b    <= 16'h0000;
            r_alu_code <= 5'h00;
            r_rd       <= 3'h0;
        end else if (w_accept) begin
            r_alu_a    <= r_rf[w_ra];
            r_alu_b    <= r_rf[w_rb];
            r_alu_code <= in_instr[15:11];
            r_rd       <= in_instr[10:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_rd    <= 3'h0;
            r_res_data  <= 16'h0000;
            r_res_ovf   <= 1'b0;
        end else begin
            r_res_valid <= w_wb_en;
            if (w_wb_en) begin
                r_res_rd   <= r_rd;
                r_res_data <= alu_c;
                r_res_ovf  <= w_ovf_masked;
            end
        end
    end

`ifdef STICKY_OVF_EN
    logic r_ovf_sticky;

    // A new overflow takes priority over a clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst)                         r_ovf_sticky <= 1'b0;
        else if (w_wb_en && w_ovf_masked) r_ovf_sticky <= 1'b1;
        else if (ovf_clr)                r_ovf_sticky <= 1'b0;
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    assign ovf_sticky = 1'b0;
`endif

    assign rd_data   = r_rf[rd_addr];
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_code  = r_alu_code;
    assign res_valid = r_res_valid;
    assign res_rd    = r_res_rd;
    assign res_data  = r_res_data;
    assign res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: adder ALU model, directed cases then randomized instructions vs a regfile model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_code;
    logic [15:0] alu_c;
    logic        alu_ovf;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        ovf_sticky;
    logic        ovf_clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mrf [0:7];
    logic        exp_sticky = 1'b0;

    always #5 clk = ~clk;

    assign alu_c   = alu_a + alu_b;
    assign alu_ovf = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_c(alu_c), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_ovf(res_ovf),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input logic [2:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
        if (addr != 3'd0) mrf[addr] = data;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx);
        rd_addr = idx;
        #1;
        chk(tag, rd_data, mrf[idx]);
    endtask

    // hw_when: 0 none, 1 host write in the accept cycle, 2 host write in the ISSUE cycle.
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic hold, input logic clr,
                         input int hw_when, input logic [2:0] hw_addr, input logic [15:0] hw_data);
        logic [15:0] a, b, sum;
        logic        ovf;
        a   = mrf[ra];
        b   = mrf[rb];
        sum = a + b;
        ovf = (a[15] == b[15]) && (sum[15] != a[15]) && (op[4:3] == 2'b00);
        in_instr = {op, rd, ra, rb, 2'($urandom_range(0, 3))};
        in_valid = 1'b1;
        if (hw_when == 1) begin
            wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data;
        end
        chk("in_ready_idle", {15'd0, in_ready}, 16'd1);
        tick();
        wr_en = 1'b0;
        if (hw_when == 1 && hw_addr != 3'd0) mrf[hw_addr] = hw_data;
        if (hold) in_instr = 16'($urandom);
        else      in_valid = 1'b0;
        ovf_clr = clr;
        if (hw_when == 2) begin
            wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data;
        end
        chk("in_ready_issue", {15'd0, in_ready}, 16'd0);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_code", {11'd0, alu_code}, {11'd0, op});
        chk("res_valid_issue", {15'd0, res_valid}, 16'd0);
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        if (hw_when == 2 && hw_addr != 3'd0 && hw_addr != rd) mrf[hw_addr] = hw_data;
        if (rd != 3'd0) mrf[rd] = sum;
`ifdef STICKY_OVF_EN
        if (ovf)      exp_sticky = 1'b1;
        else if (clr) exp_sticky = 1'b0;
`endif
        chk("res_valid", {15'd0, res_valid}, 16'd1);
        chk("res_rd", {13'd0, res_rd}, {13'd0, rd});
        chk("res_data", res_data, sum);
        chk("res_ovf", {15'd0, res_ovf}, {15'd0, ovf});
        chk("ovf_sticky", {15'd0, ovf_sticky}, {15'd0, exp_sticky});
        chk("in_ready_back", {15'd0, in_ready}, 16'd1);
        check_reg("rd_writeback", rd);
        if (hw_when != 0) check_reg("host_write_reg", hw_addr);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; wr_en = 1'b0; wr_addr = 3'd0;
        wr_data = 16'h0; rd_addr = 3'd0; ovf_clr = 1'b0;
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_alu_a", alu_a, 16'h0);
        chk("rst_alu_b", alu_b, 16'h0);
        chk("rst_alu_code", {11'd0, alu_code}, 16'h0);
        chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_res_data", res_data, 16'h0);
        chk("rst_res_ovf", {15'd0, res_ovf}, 16'd0);
        chk("rst_ovf_sticky", {15'd0, ovf_sticky}, 16'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_rf", 3'(i));

        // Load and add, then dependent chain r4 = r3 + r3.
        hwrite(3'd1, 16'h0003);
        hwrite(3'd2, 16'h0004);
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 0, 3'd0, 16'h0);
        chk("add_r3_const", mrf[3], 16'h0007);
        issue(5'b00000, 3'd4, 3'd3, 3'd3, 1'b0, 1'b0, 0, 3'd0, 16'h0);
        rd_addr = 3'd4; #1;
        chk("chain_r4_const", rd_data, 16'h000E);

        // Overflow in arithmetic group, masked in logic group, clear behaviour.
        hwrite(3'd1, 16'h7FFF);
        hwrite(3'd2, 16'h0001);
        issue(5'b00001, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 0, 3'd0, 16'h0);
        chk("ovf_res_const", mrf[6], 16'h8000);
        issue(5'b01001, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 0, 3'd0, 16'h0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_sticky = 1'b0;
        chk("sticky_cleared", {15'd0, ovf_sticky}, 16'd0);
        issue(5'b00010, 3'd7, 3'd1, 3'd2, 1'b0, 1'b1, 0, 3'd0, 16'h0);

        // r0 writes discarded; writeback vs host write conflicts; operand read vs same-cycle write.
        issue(5'b00000, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 0, 3'd0, 16'h0);
        hwrite(3'd0, 16'hFFFF);
        check_reg("r0_zero", 3'd0);
        hwrite(3'd1, 16'h1000);
        hwrite(3'd2, 16'h0234);
        issue(5'b00000, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 2, 3'd5, 16'hAAAA);
        rd_addr = 3'd5; #1;
        chk("conflict_r5_const", rd_data, 16'h1234);
        issue(5'b00000, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 2, 3'd6, 16'h5555);
        issue(5'b00000, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 1, 3'd1, 16'h0F0F);

        // Continuous in_valid: one accept per two cycles, junk during ISSUE ignored.
        for (int k = 0; k < 6; k++)
            issue(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b1, 1'b0, 0, 3'd0, 16'h0);
        in_valid = 1'b0;
        tick();
        chk("no_dup_res_valid", {15'd0, res_valid}, 16'd0);

        // Randomized instruction stream.
        for (int i = 1; i < 8; i++) hwrite(3'(i), 16'($urandom));
        for (int k = 0; k < 40; k++)
            issue(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), $urandom_range(0, 2), 3'($urandom), 16'($urandom));
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) check_reg("rand_rf", 3'(i));

        // Reset during ISSUE discards the writeback.
        hwrite(3'd1, 16'h7FFF);
        in_instr = {5'b00000, 3'd2, 3'd1, 3'd1, 2'b00};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_in_ready", {15'd0, in_ready}, 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
        exp_sticky = 1'b0;
        chk("mid_rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("mid_rst_alu_a", alu_a, 16'h0);
        chk("mid_rst_sticky", {15'd0, ovf_sticky}, 16'd0);
        tick();
        chk("post_rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("post_rst_res_valid", {15'd0, res_valid}, 16'd0);
        for (int i = 0; i < 8; i++) check_reg("post_rst_rf", 3'(i));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
